// File: rtl/retire_map_if.sv
// Retire map bus: commit bundle in, released physical registers and the
// committed architectural map out. The commit lane type lives here so that the
// map and whoever drives it agree on field widths.
interface retire_map_if #(
   parameter int cwd = 4,
   parameter int rwd = 4,
   parameter int nlr = 32,
   parameter int npr = 128
);
   localparam int pw = $clog2(npr);
   localparam int lw = $clog2(nlr);

   typedef struct packed {
      logic [15:0]   opid;
      logic          redir;
      logic          rollback;
      logic [lw-1:0] lrda;
      logic [pw-1:0] prda;
   } com_bundle_t;

   com_bundle_t [cwd-1:0]     com_bundle;
   logic [rwd-1:0]            rel_valid;
   logic [rwd-1:0][pw-1:0]    rel_preg;
   logic                      rel_ready;
   logic [nlr-1:0][pw-1:0]    amap;
   logic [pw:0]               rel_cnt;
   logic                      overflow;

   modport master (
      output com_bundle, rel_ready,
      input  rel_valid, rel_preg, amap, rel_cnt, overflow
   );

   modport slave (
      input  com_bundle, rel_ready,
      output rel_valid, rel_preg, amap, rel_cnt, overflow
   );
endinterface

// File: rtl/retire_map.sv
// Committed architectural register map. Each retiring writer replaces the
// mapping of its destination and hands the previous physical register to a
// circular release FIFO that drains towards the rename free list.
module retire_map #(
   parameter int cwd = 4,
   parameter int rwd = 4,
   parameter int nlr = 32,
   parameter int npr = 128
) (
   input  logic        clk,
   input  logic        rst,
   retire_map_if.slave bus
);
   localparam int pw    = $clog2(npr);
   localparam int depth = npr - nlr;

   typedef logic [pw:0] ext_t;

   logic [nlr-1:0][pw-1:0] amap_r;
   logic [nlr-1:0][pw-1:0] amap_s;
   logic [pw-1:0]          mem_r [depth];
   logic [pw-1:0]          head_r;
   logic [pw-1:0]          tail_r;
   logic [pw-1:0]          head_s;
   logic [pw-1:0]          tail_s;
   ext_t                   cnt_r;
   ext_t                   cnt_s;
   ext_t                   pop_s;
   ext_t                   push_s;
   ext_t                   room_s;
   ext_t                   acc_s;
   logic                   ovf_r;
   logic                   ovf_set_s;
   logic [cwd-1:0]         qual_s;
   logic [cwd-1:0]         wr_en_s;
   logic [cwd-1:0][pw-1:0] wr_ptr_s;
   logic [cwd-1:0][pw-1:0] old_s;
   logic [cwd-1:0][pw:0]   off_s;
   logic [rwd-1:0]         rel_valid_s;
   logic [rwd-1:0][pw-1:0] rel_preg_s;

   // Advance a FIFO pointer by n slots, wrapping at the (non power of two) depth.
   function automatic logic [pw-1:0] ptr_add(input logic [pw-1:0] p, input ext_t n);
      ext_t sum;
      sum = ext_t'(p) + n;
      if (sum >= ext_t'(depth)) begin
         sum = sum - ext_t'(depth);
      end else begin
         sum = sum;
      end
      return sum[pw-1:0];
   endfunction

   // Walk lanes oldest first so same-cycle writers to one register chain correctly.
   always_comb begin
      amap_s = amap_r;
      push_s = '0;
      qual_s = '0;
      old_s  = '0;
      off_s  = '0;
      for (int i = 0; i < cwd; i++) begin
         qual_s[i] = bus.com_bundle[i].opid[15] && !bus.com_bundle[i].rollback &&
                     !bus.com_bundle[i].redir && (bus.com_bundle[i].lrda != '0);
         off_s[i]  = push_s;
         if (qual_s[i]) begin
            old_s[i]                      = amap_s[bus.com_bundle[i].lrda];
            amap_s[bus.com_bundle[i].lrda] = bus.com_bundle[i].prda;
            push_s                        = push_s + ext_t'(1);
         end else begin
            old_s[i] = '0;
         end
      end
   end

   // Occupancy bookkeeping: pops first, then as many pushes as the freed room allows.
   always_comb begin
      if (bus.rel_ready) begin
         if (cnt_r < ext_t'(rwd)) begin
            pop_s = cnt_r;
         end else begin
            pop_s = ext_t'(rwd);
         end
      end else begin
         pop_s = '0;
      end
      room_s = ext_t'(depth) - cnt_r + pop_s;
      if (push_s > room_s) begin
         acc_s     = room_s;
         ovf_set_s = 1'b1;
      end else begin
         acc_s     = push_s;
         ovf_set_s = 1'b0;
      end
      cnt_s  = cnt_r - pop_s + acc_s;
      head_s = ptr_add(head_r, pop_s);
      tail_s = ptr_add(tail_r, acc_s);
      wr_en_s  = '0;
      wr_ptr_s = '0;
      for (int i = 0; i < cwd; i++) begin
         wr_en_s[i]  = qual_s[i] && (off_s[i] < acc_s);
         wr_ptr_s[i] = ptr_add(tail_r, off_s[i]);
      end
   end

   // Release window: the oldest rwd FIFO slots, driven purely from registered state.
   always_comb begin
      rel_valid_s = '0;
      rel_preg_s  = '0;
      for (int k = 0; k < rwd; k++) begin
         rel_valid_s[k] = cnt_r > ext_t'(k);
         rel_preg_s[k]  = mem_r[ptr_add(head_r, ext_t'(k))];
      end
   end

   // State update; reset restores the identity map and empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < nlr; i++) begin
            amap_r[i] <= pw'(i);
         end
         for (int i = 0; i < depth; i++) begin
            mem_r[i] <= '0;
         end
         head_r <= '0;
         tail_r <= '0;
         cnt_r  <= '0;
         ovf_r  <= 1'b0;
      end else begin
         amap_r <= amap_s;
         head_r <= head_s;
         tail_r <= tail_s;
         cnt_r  <= cnt_s;
         for (int i = 0; i < cwd; i++) begin
            if (wr_en_s[i]) begin
               mem_r[wr_ptr_s[i]] <= old_s[i];
            end
         end
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   assign bus.amap      = amap_r;
   assign bus.rel_cnt   = cnt_r;
   assign bus.overflow  = ovf_r;
   assign bus.rel_valid = rel_valid_s;
   assign bus.rel_preg  = rel_preg_s;
endmodule

// File: tb/tb_retire_map.sv
// Bench for retire_map: directed scenarios plus random traffic, checked against
// a map-array / queue reference model.
module tb_retire_map;
   localparam int cwd = 4;
   localparam int rwd = 4;
   localparam int nlr = 32;
   localparam int npr = 128;
   localparam int pw = 7;
   localparam int depth = npr - nlr;

   logic clk;
   logic rst;

   retire_map_if #(.cwd(cwd), .rwd(rwd), .nlr(nlr), .npr(npr)) bus();
   retire_map #(.cwd(cwd), .rwd(rwd), .nlr(nlr), .npr(npr)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model
   int amap_m[nlr];
   int q[$];
   bit ovf_m;
   bit l_v[cwd];
   bit l_rb[cwd];
   bit l_rd[cwd];
   int l_lr[cwd];
   int l_pr[cwd];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_lane(input int i, input bit v, input bit rb, input bit rd,
                           input int lr, input int pr);
      l_v[i] = v; l_rb[i] = rb; l_rd[i] = rd; l_lr[i] = lr; l_pr[i] = pr;
      bus.com_bundle[i].opid     = {v, 15'($urandom)};
      bus.com_bundle[i].rollback = rb;
      bus.com_bundle[i].redir    = rd;
      bus.com_bundle[i].lrda     = 5'(lr);
      bus.com_bundle[i].prda     = 7'(pr);
   endtask

   task automatic clear_lanes();
      for (int i = 0; i < cwd; i++) set_lane(i, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic rand_lanes(input int lr_max);
      for (int i = 0; i < cwd; i++)
         set_lane(i, ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
                  $urandom_range(0, lr_max), $urandom_range(0, npr - 1));
   endtask

   task automatic full_lanes();
      for (int i = 0; i < cwd; i++)
         set_lane(i, 1'b1, 1'b0, 1'b0, $urandom_range(1, nlr - 1), $urandom_range(0, npr - 1));
   endtask

   // one retirement cycle of the architectural rules
   task automatic model_update();
      int pops;
      int old;
      if (rst) begin
         for (int i = 0; i < nlr; i++) amap_m[i] = i;
         q.delete();
         ovf_m = 1'b0;
      end else begin
         pops = 0;
         if (bus.rel_ready) pops = (q.size() < rwd) ? q.size() : rwd;
         repeat (pops) void'(q.pop_front());
         for (int i = 0; i < cwd; i++) begin
            if (l_v[i] && !l_rb[i] && !l_rd[i] && l_lr[i] != 0) begin
               old = amap_m[l_lr[i]];
               amap_m[l_lr[i]] = l_pr[i];
               if (q.size() < depth) q.push_back(old);
               else ovf_m = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic check_all(input string tag);
      logic [rwd-1:0] ev;
      logic [nlr-1:0][pw-1:0] ea;
      for (int k = 0; k < rwd; k++) ev[k] = q.size() > k;
      for (int i = 0; i < nlr; i++) ea[i] = pw'(amap_m[i]);
      chk({tag, ".cnt"}, bus.rel_cnt, q.size());
      chk({tag, ".valid"}, bus.rel_valid, ev);
      chk({tag, ".ovf"}, bus.overflow, ovf_m);
      chk({tag, ".amap"}, bus.amap, ea);
      for (int k = 0; k < rwd && k < q.size(); k++)
         chk({tag, ".preg"}, bus.rel_preg[k], q[k]);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.rel_ready = 1'b0;
      clear_lanes();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [nlr-1:0][pw-1:0] ident;
      for (int i = 0; i < nlr; i++) ident[i] = pw'(i);
      rst = 1'b1;
      bus.rel_ready = 1'b0;
      clear_lanes();

      // reset state
      do_reset();
      check_all("reset");
      chk("reset.amap_id", bus.amap, ident);
      chk("reset.preg0", bus.rel_preg, 0);
      chk("reset.valid0", bus.rel_valid, 4'b0000);

      // single commit
      set_lane(0, 1'b1, 1'b0, 1'b0, 5, 40);
      step();
      clear_lanes();
      check_all("single");
      chk("single.amap5", bus.amap[5], 40);
      chk("single.valid", bus.rel_valid, 4'b0001);
      chk("single.preg0", bus.rel_preg[0], 5);
      chk("single.cnt", bus.rel_cnt, 1);

      // same-cycle chain on one register
      do_reset();
      set_lane(0, 1'b1, 1'b0, 1'b0, 3, 50);
      set_lane(1, 1'b1, 1'b0, 1'b0, 3, 51);
      step();
      clear_lanes();
      check_all("chain");
      chk("chain.amap3", bus.amap[3], 51);
      chk("chain.preg0", bus.rel_preg[0], 3);
      chk("chain.preg1", bus.rel_preg[1], 50);
      chk("chain.cnt", bus.rel_cnt, 2);

      // filtered lanes
      set_lane(0, 1'b1, 1'b0, 1'b0, 0, 60);
      set_lane(1, 1'b1, 1'b1, 1'b0, 7, 61);
      set_lane(2, 1'b1, 1'b0, 1'b1, 8, 62);
      set_lane(3, 1'b0, 1'b0, 1'b0, 9, 63);
      step();
      clear_lanes();
      check_all("filter");
      chk("filter.cnt", bus.rel_cnt, 2);
      chk("filter.amap7", bus.amap[7], 7);

      // backpressure then drain
      do_reset();
      for (int c = 0; c < 10; c++) begin
         full_lanes();
         step();
      end
      clear_lanes();
      check_all("bp");
      chk("bp.cnt40", bus.rel_cnt, 40);
      chk("bp.ovf", bus.overflow, 1'b0);
      bus.rel_ready = 1'b1;
      step();
      chk("bp.cnt36", bus.rel_cnt, 36);
      step();
      chk("bp.cnt32", bus.rel_cnt, 32);
      check_all("bp.drain");

      // wrap: fill 94, drain all, push 4, then push 3 while popping 4
      do_reset();
      for (int c = 0; c < 24; c++) begin
         full_lanes();
         if (c == 23) begin
            set_lane(2, 1'b0, 1'b0, 1'b0, 1, 0);
            set_lane(3, 1'b0, 1'b0, 1'b0, 1, 0);
         end
         step();
      end
      clear_lanes();
      chk("wrap.cnt94", bus.rel_cnt, 94);
      bus.rel_ready = 1'b1;
      for (int c = 0; c < 24; c++) step();
      chk("wrap.empty", bus.rel_cnt, 0);
      bus.rel_ready = 1'b0;
      full_lanes();
      step();
      check_all("wrap.four");
      full_lanes();
      set_lane(3, 1'b0, 1'b0, 1'b0, 1, 0);
      bus.rel_ready = 1'b1;
      step();
      clear_lanes();
      bus.rel_ready = 1'b0;
      check_all("wrap.three");
      chk("wrap.cnt3", bus.rel_cnt, 3);

      // overflow
      do_reset();
      for (int c = 0; c < 24; c++) begin
         full_lanes();
         step();
      end
      clear_lanes();
      chk("ovf.cnt96", bus.rel_cnt, 96);
      chk("ovf.pre", bus.overflow, 1'b0);
      set_lane(0, 1'b1, 1'b0, 1'b0, 4, 90);
      step();
      clear_lanes();
      check_all("ovf.push");
      chk("ovf.set", bus.overflow, 1'b1);
      chk("ovf.sat", bus.rel_cnt, 96);
      step();
      chk("ovf.sticky", bus.overflow, 1'b1);
      do_reset();
      chk("ovf.clr", bus.overflow, 1'b0);
      chk("ovf.amap_id", bus.amap, ident);

      // reset in the middle of traffic
      full_lanes();
      step();
      full_lanes();
      bus.rel_ready = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_lanes();
      chk("midrst.valid", bus.rel_valid, 4'b0000);
      chk("midrst.cnt", bus.rel_cnt, 0);
      check_all("midrst");

      // random traffic: balanced phase, then starved consumer
      for (int c = 0; c < 400; c++) begin
         bus.rel_ready = (c < 250) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
         rst = ($urandom % 97) == 0;
         rand_lanes((c % 2 == 0) ? 7 : nlr - 1);
         step();
         check_all("rand");
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
